// File: rtl/pbit_tanh_engine.sv
// Pipelined tanh activation for the p-bit array: run-time writable positive-half table,
// odd symmetry, optional linear interpolation, valid/ready handshake with global stall.
module pbit_tanh_engine #(
    parameter int unsigned IN_W   = 9,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned FRAC_W = 2,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned INTERP = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [OUT_W-2:0]    wr_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     in_x,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_y
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned MAG_W = OUT_W - 1;
    localparam int unsigned FW    = (FRAC_W > 0) ? FRAC_W : 1;
    localparam int unsigned PW    = OUT_W + FW + 1;
    localparam logic [PW-1:0] MAX_MAG = PW'({MAG_W{1'b1}});
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [MAG_W-1:0] r_tbl [DEPTH];

    logic              r_s1_v, r_s1_s, r_s1_z;
    logic [ADDR_W-1:0] r_s1_idx;
    logic [FW-1:0]     r_s1_f;
    logic              r_s2_v, r_s2_s, r_s2_z;
    logic [FW-1:0]     r_s2_f;
    logic [MAG_W-1:0]  r_s2_a, r_s2_b;
    logic              r_out_valid;
    logic [OUT_W-1:0]  r_out_y;

    logic                 w_adv;
    logic [IN_W-1:0]      w_m, w_idx_raw;
    logic                 w_sat, w_zero;
    logic [ADDR_W-1:0]    w_idx, w_idx_p1;
    logic [FW-1:0]        w_frac;
    logic signed [OUT_W-1:0] w_d;
    logic signed [PW-1:0] w_prod, w_p, w_sum;
    logic [MAG_W-1:0]     w_clamp, w_y;
    logic                 w_neg;

    assign w_adv     = ~r_out_valid | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;

    // S1: magnitude (most-negative input maps to 2^(IN_W-1)), index/fraction split, saturation
    always_comb begin
        w_m       = in_x[IN_W-1] ? (~in_x + IN_W'(1)) : in_x;
        w_idx_raw = w_m >> FRAC_W;
        w_sat     = 32'(w_idx_raw) >= (DEPTH - 1);
        w_zero    = (w_m == '0);
        w_idx     = w_sat ? LAST : ADDR_W'(w_idx_raw);
        w_frac    = (FRAC_W == 0 || w_sat) ? '0 : w_m[FW-1:0];
    end

    assign w_idx_p1 = (r_s1_idx == LAST) ? LAST : r_s1_idx + ADDR_W'(1);

    // S3: a + floor(d*f / 2^FRAC_W), clamped to the magnitude range
    always_comb begin
        w_d    = $signed({1'b0, r_s2_b}) - $signed({1'b0, r_s2_a});
        w_prod = PW'(w_d) * PW'($signed({1'b0, r_s2_f}));
        w_p    = w_prod >>> FRAC_W;
        w_sum  = PW'($signed({1'b0, r_s2_a})) + w_p;
        if (w_sum[PW-1])
            w_clamp = '0;
        else if (w_sum > $signed(MAX_MAG))
            w_clamp = {MAG_W{1'b1}};
        else
            w_clamp = MAG_W'(w_sum);
        w_y   = (INTERP != 0 && FRAC_W != 0) ? w_clamp : r_s2_a;
        w_neg = r_s2_s & ~r_s2_z & (w_y != '0);
    end

    // Table writes ignore the handshake; a same-edge S2 read sees the old entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) r_tbl[k] <= '0;
        end else if (wr_en) begin
            r_tbl[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v      <= 1'b0;
            r_s1_s      <= 1'b0;
            r_s1_z      <= 1'b0;
            r_s1_idx    <= '0;
            r_s1_f      <= '0;
            r_s2_v      <= 1'b0;
            r_s2_s      <= 1'b0;
            r_s2_z      <= 1'b0;
            r_s2_f      <= '0;
            r_s2_a      <= '0;
            r_s2_b      <= '0;
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
        end else if (w_adv) begin
            r_s1_v      <= in_valid;
            r_s1_s      <= in_x[IN_W-1];
            r_s1_z      <= w_zero;
            r_s1_idx    <= w_idx;
            r_s1_f      <= w_frac;
            r_s2_v      <= r_s1_v;
            r_s2_s      <= r_s1_s;
            r_s2_z      <= r_s1_z;
            r_s2_f      <= r_s1_f;
            r_s2_a      <= r_tbl[r_s1_idx];
            r_s2_b      <= r_tbl[w_idx_p1];
            r_out_valid <= r_s2_v;
            r_out_y     <= r_s2_v ? {w_neg, w_y} : '0;
        end
    end
endmodule

// File: tb/tb_pbit_tanh_engine.sv
// Directed bench for pbit_tanh_engine: scoreboard of expected results, checked on the falling edge.
module tb_pbit_tanh_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [30:0] wr_data;
    logic        in_valid, in_ready;
    logic [8:0]  in_x;
    logic        out_valid, out_ready;
    logic [31:0] out_y;
    logic        ni_in_ready, ni_out_valid;
    logic        ni_out_ready;
    logic [31:0] ni_out_y;

    always #5 clk = ~clk;

    pbit_tanh_engine u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
    );

    pbit_tanh_engine #(.INTERP(0)) u_ni (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .in_valid(in_valid), .in_ready(ni_in_ready), .in_x(in_x),
        .out_valid(ni_out_valid), .out_ready(ni_out_ready), .out_y(ni_out_y)
    );

    localparam logic [31:0] NEG = 32'h8000_0000;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          pop_cyc = 0;
    int          popped = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_in;
    logic        stall_prev = 1'b0;
    logic [31:0] y_prev;
    logic [31:0] ni_last_y = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock: observe handshakes at the falling edge, then return just after the rising edge
    task automatic tick(output logic acc);
        @(negedge clk);
        cyc++;
        acc = in_valid && in_ready;
        if (acc) begin
            sb.push_back(exp_in);
            acc_cyc = cyc;
        end
        if (stall_prev && out_valid) chk("stall_hold", out_y, y_prev);
        if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("sb_unexpected_out", 32'(sb.size()), 32'd1);
            else begin
                chk("result", out_y, sb.pop_front());
                popped++;
                pop_cyc = cyc;
            end
        end
        if (ni_out_valid) ni_last_y = ni_out_y;
        stall_prev = out_valid && !out_ready;
        y_prev     = out_y;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [8:0] x, input logic [31:0] e, output int tries);
        logic a;
        in_valid = 1'b1;
        in_x     = x;
        exp_in   = e;
        tries    = 0;
        do begin
            tick(a);
            tries++;
        end while (!a && tries < 50);
        if (!a) chk("send_timeout", 32'(a), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int k = 0; k < n; k++) tick(a);
    endtask

    task automatic wr(input int addr, input int data);
        logic a;
        wr_en   = 1'b1;
        wr_addr = 6'(addr);
        wr_data = 31'(data);
        tick(a);
        wr_en   = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sb.size() != 0; k++) idle(1);
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int  t;
        int  idx;
        int  base;
        logic a;
        rst_n        = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        in_valid     = 1'b0;
        in_x         = '0;
        out_ready    = 1'b1;
        ni_out_ready = 1'b1;
        exp_in       = '0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_y", out_y, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 64; k++) wr(k, 1024 * k);

        send(9'd5, 32'd1280, t);
        idle(4);
        chk("latency", 32'(pop_cyc - acc_cyc), 32'd3);

        send(9'h1FB, NEG | 32'd1280, t);
        send(9'd0, 32'd0, t);
        send(9'h1FF, NEG | 32'd256, t);
        send(9'd255, 32'd64512, t);
        send(9'h100, NEG | 32'd64512, t);
        send(9'd252, 32'd64512, t);
        drain();

        send(9'd7, 32'd1792, t);
        idle(4);
        chk("nointerp_7", ni_last_y, 32'd1024);

        // Back-to-back stream of 1..20 with out_ready low for cycles 4..9
        base = popped;
        idx  = 1;
        for (int c = 0; c < 80 && (idx <= 20 || sb.size() != 0); c++) begin
            out_ready = !(c >= 4 && c <= 9);
            in_valid  = (idx <= 20);
            in_x      = 9'(idx);
            exp_in    = 32'(256 * idx);
            tick(a);
            if (a) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", 32'(popped - base), 32'd20);
        drain();

        // Table write racing an S2 read of the same entry
        send(9'd4, 32'd1024, t);
        wr(1, 5000);
        send(9'd4, 32'd5000, t);
        wr(2, 0);
        send(9'd6, 32'd2500, t);
        drain();

        // Reset with words in flight
        send(9'd10, 32'd2560, t);
        send(9'd11, 32'd2816, t);
        send(9'd12, 32'd3072, t);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_y", out_y, 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(9'd5, 32'd0, t);
        chk("accept_first_after_rst", 32'(t), 32'd1);
        send(9'd255, 32'd0, t);
        drain();
        idle(3);
        chk("no_extra_out", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
